// File: rtl/pulse_stretcher_if.sv
// Event/level bundle between an event source and pulse_stretcher.
// master: event source driving pulse_in; slave: the stretcher itself.
interface pulse_stretcher_if;
    logic       pulse_in;
    logic       out;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    modport master (
        output pulse_in,
        input  out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns 1-cycle event strobes into HOLD_CYCLES-wide high
// levels, each followed by a GAP_CYCLES low interval.
// Optional feature macro: PULSE_STRETCHER_QUEUE_EN (3-bit event queue with
// pending count and overflow strobe). Without it, events arriving while
// busy are dropped and pending/overflow read 0.
module pulse_stretcher #(
    parameter int unsigned HOLD_CYCLES = 5000000,
    parameter int unsigned GAP_CYCLES  = 2500000
) (
    input  logic              clk,
    input  logic              rst,
    pulse_stretcher_if.slave  bus
);

    localparam int unsigned CNT_W  = 24;
    localparam int unsigned PEND_W = 3;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;

`ifdef PULSE_STRETCHER_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(7);

    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              push;
`endif

    // Next-state, counter and queue bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef PULSE_STRETCHER_QUEUE_EN
        pending_d  = pending_q;
        overflow_d = 1'b0;
        push       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.pulse_in) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`ifdef PULSE_STRETCHER_QUEUE_EN
                push = bus.pulse_in;
`endif
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef PULSE_STRETCHER_QUEUE_EN
                    push = bus.pulse_in;
`endif
                end else begin
`ifdef PULSE_STRETCHER_QUEUE_EN
                    // Final gap cycle: a queued event wins; a same-cycle
                    // strobe replaces the one dequeued (net zero).
                    if (pending_q != '0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                        if (!bus.pulse_in) begin
                            pending_d = pending_q - PEND_W'(1);
                        end
                    end else if (bus.pulse_in) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef PULSE_STRETCHER_QUEUE_EN
        // Enqueue while busy; a saturated queue discards and flags the event
        if (push) begin
            if (pending_q != PEND_MAX) begin
                pending_d = pending_q + PEND_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
`endif

        out_d  = (state_d == HOLD);
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
            pending_q  <= '0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
`ifdef PULSE_STRETCHER_QUEUE_EN
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
`ifdef PULSE_STRETCHER_QUEUE_EN
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;
`else
    assign bus.pending  = '0;
    assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HOLD_CYCLES=4, GAP_CYCLES=2.
// Follows PULSE_STRETCHER_QUEUE_EN the same way the design does.
module tb_pulse_stretcher;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pulse_stretcher_if bus ();

    pulse_stretcher #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: strobe value p is sampled at the edge; outputs read 1 time unit later
    task automatic cyc(input logic p);
        bus.pulse_in = p;
        @(posedge clk);
        #1;
        bus.pulse_in = 1'b0;
    endtask

    // Bit i of each vector refers to edge i: strobe applied, out/busy after it;
    // pend holds 4 bits per edge (expected pending after that edge)
    task automatic run_pattern(input string tag, input int n,
                               input logic [63:0] pulses, input logic [63:0] outs,
                               input logic [63:0] busys, input logic [79:0] pend);
        for (int i = 0; i < n; i++) begin
            cyc(pulses[i]);
            chk($sformatf("%s_out%0d", tag, i), 32'(bus.out), 32'(outs[i]));
            chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'(busys[i]));
            chk($sformatf("%s_pend%0d", tag, i), 32'(bus.pending), 32'(pend[i*4 +: 3]));
            chk($sformatf("%s_ovf%0d", tag, i), 32'(bus.overflow), 32'd0);
        end
    endtask

    initial begin
        int   exp_p [9];
        int   rises;
        int   ovfs;
        int   done_at;
        logic prev_out;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.pulse_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out",  32'(bus.out),      32'd0);
        chk("rst_busy", 32'(bus.busy),     32'd0);
        chk("rst_pend", 32'(bus.pending),  32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        rst = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Single event: 4 high, 2 low busy, then idle
        run_pattern("single", 8, 64'h01, 64'h0F, 64'h3F, 80'h0);

`ifdef PULSE_STRETCHER_QUEUE_EN
        // Events at edges 0, 2, 3: three holds, period 6
        run_pattern("queue3", 20, 64'h0D, 64'hF3CF, 64'h3FFFF,
                    80'h0000_0000_1111_1122_2100);

        // Strobe on final gap cycle with empty queue: immediate back-to-back hold
        run_pattern("lastgap", 14, 64'h41, 64'h3CF, 64'hFFF, 80'h0);

        // Nine strobes on edges 1..9; the edge-6 one coincides with the
        // final gap cycle (net-zero dequeue), the edge-9 one overflows
        exp_p = '{1, 2, 3, 4, 5, 5, 6, 7, 7};
        cyc(1'b1);
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1);
            chk($sformatf("sat_pend%0d", i), 32'(bus.pending), 32'(exp_p[i-1]));
            chk($sformatf("sat_ovf%0d", i), 32'(bus.overflow), (i == 9) ? 32'd1 : 32'd0);
        end
        chk("sat_out9", 32'(bus.out), 32'd1);
        rises    = 0;
        ovfs     = 0;
        done_at  = 0;
        prev_out = bus.out;
        for (int c = 1; c <= 100; c++) begin
            cyc(1'b0);
            if (bus.out && !prev_out) rises++;
            if (bus.overflow) ovfs++;
            prev_out = bus.out;
            if (!bus.busy) begin
                done_at = c;
                break;
            end
        end
        chk("sat_holds",  32'(rises),   32'd7);
        chk("sat_ovf_after", 32'(ovfs), 32'd0);
        chk("sat_drain",  32'(done_at), 32'd45);
        chk("sat_pend_end", 32'(bus.pending), 32'd0);
`else
        // Strobes during hold and on the final gap cycle are dropped
        run_pattern("drop", 10, 64'h45, 64'h0F, 64'h3F, 80'h0);
        cyc(1'b0);
        chk("drop_idle", 32'(bus.busy), 32'd0);
`endif

        // Asynchronous reset mid-hold clears everything without a clock edge
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        chk("pre_rst_out", 32'(bus.out), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_out",  32'(bus.out),     32'd0);
        chk("arst_busy", 32'(bus.busy),    32'd0);
        chk("arst_pend", 32'(bus.pending), 32'd0);
        bus.pulse_in = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pulse_ignored", 32'(bus.busy), 32'd0);
        bus.pulse_in = 1'b0;
        rst = 1'b0;
        cyc(1'b0);
        chk("post_rst_idle", 32'(bus.busy), 32'd0);
        run_pattern("post_rst", 8, 64'h01, 64'h0F, 64'h3F, 80'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
